// File: rtl/flappy_pkg.sv
// Shared game types and screen/playfield constants for the flappy pipeline
// (bird, pipe and collision blocks).
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DYING   = 2'd2,
    OVER    = 2'd3
  } game_state_t;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int DEF_PIPE_W  = 40;
  localparam int DEF_FLOOR_Y = 479;

endpackage

// File: rtl/bird_collision_fsm_box_hit.sv
// Combinational bird-vs-world hit terms: floor, ceiling, pipe and pipe-passed.
// Pipe edges are evaluated at N+1 bits so a pipe near the right border never wraps.
module box_hit #(
  parameter int N       = 10,
  parameter int PIPE_W  = 40,
  parameter int FLOOR_Y = 479
) (
  input  logic [N-1:0] bird_x0,
  input  logic [N-1:0] bird_x1,
  input  logic [N-1:0] bird_y0,
  input  logic [N-1:0] bird_y1,
  input  logic [N-1:0] pipe_x,
  input  logic [N-1:0] gap_top,
  input  logic [N-1:0] gap_bot,
  output logic         floor_hit,
  output logic         ceil_hit,
  output logic         pipe_hit,
  output logic         passed
);

  localparam logic [N:0] FLOOR_V = (N+1)'(FLOOR_Y);
  localparam logic [N:0] PW      = (N+1)'(PIPE_W);
  localparam logic [N:0] PW_M1   = (N+1)'(PIPE_W - 1);

  logic [N:0] pipe_l;
  logic [N:0] pipe_r;
  logic [N:0] pipe_end;
  logic       h_overlap;
  logic       v_miss;

  assign pipe_l   = {1'b0, pipe_x};
  assign pipe_r   = pipe_l + PW_M1;
  assign pipe_end = pipe_l + PW;

  assign floor_hit = {1'b0, bird_y0} >= FLOOR_V;
  // top edge above the bottom edge means the top coordinate underflowed
  assign ceil_hit  = (bird_y1 == '0) || (bird_y1 > bird_y0);

  assign h_overlap = ({1'b0, bird_x1} >= pipe_l) && ({1'b0, bird_x0} <= pipe_r);
  assign v_miss    = (bird_y1 < gap_top) || (bird_y0 > gap_bot);
  assign pipe_hit  = h_overlap && v_miss;

  assign passed = pipe_end < {1'b0, bird_x0};

endmodule

// File: rtl/bird_collision_fsm.sv
// Game state machine and scorekeeper for the flappy pipeline.
// Optional HIGH_SCORE_EN builds a persistent best-score register.
module bird_collision_fsm
  import flappy_pkg::*;
#(
  parameter int N           = 10,
  parameter int PIPE_W      = DEF_PIPE_W,
  parameter int FLOOR_Y     = DEF_FLOOR_Y,
  parameter int SCORE_W     = 8,
  parameter int DEATH_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [N-1:0]       bird_x0,
  input  logic [N-1:0]       bird_x1,
  input  logic [N-1:0]       bird_y0,
  input  logic [N-1:0]       bird_y1,
  input  logic [N-1:0]       pipe_x,
  input  logic [N-1:0]       gap_top,
  input  logic [N-1:0]       gap_bot,
  input  logic               pipe_new,
  output logic               game_active,
  output logic               game_over,
  output logic               collide,
  output logic               score_inc,
  output logic               bird_rst,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);

  // state   | meaning
  // IDLE    | waiting for start; score from last game still shown
  // PLAYING | motion enabled, hits and passes evaluated each frame tick
  // DYING   | hit detected, counting DEATH_TICKS frame ticks
  // OVER    | game_over shown, start returns to IDLE and restarts the bird

  localparam int              CW         = $clog2(DEATH_TICKS + 1);
  localparam logic [CW-1:0]   DEATH_LAST = CW'(DEATH_TICKS - 1);

  game_state_t   state;
  logic [CW-1:0] death_cnt;
  logic          pass_armed;
  logic          floor_hit;
  logic          ceil_hit;
  logic          pipe_hit;
  logic          passed;
  logic          any_hit;

  box_hit #(
    .N       (N),
    .PIPE_W  (PIPE_W),
    .FLOOR_Y (FLOOR_Y)
  ) u_box_hit (
    .bird_x0   (bird_x0),
    .bird_x1   (bird_x1),
    .bird_y0   (bird_y0),
    .bird_y1   (bird_y1),
    .pipe_x    (pipe_x),
    .gap_top   (gap_top),
    .gap_bot   (gap_bot),
    .floor_hit (floor_hit),
    .ceil_hit  (ceil_hit),
    .pipe_hit  (pipe_hit),
    .passed    (passed)
  );

  assign any_hit = floor_hit || ceil_hit || pipe_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      death_cnt   <= '0;
      pass_armed  <= 1'b1;
      game_active <= 1'b0;
      game_over   <= 1'b0;
      collide     <= 1'b0;
      score_inc   <= 1'b0;
      bird_rst    <= 1'b0;
      score       <= '0;
`ifdef HIGH_SCORE_EN
      high_score  <= '0;
`endif
    end else begin
      collide   <= 1'b0;
      score_inc <= 1'b0;
      bird_rst  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= PLAYING;
            game_active <= 1'b1;
            score       <= '0;
          end
        end
        PLAYING: begin
          if (frame_tick) begin
            if (any_hit) begin
              state       <= DYING;
              game_active <= 1'b0;
              collide     <= 1'b1;
              death_cnt   <= '0;
            end else if (passed && pass_armed) begin
              pass_armed <= 1'b0;
              if (score != '1) begin
                score     <= score + 1'b1;
                score_inc <= 1'b1;
              end
            end
          end
        end
        DYING: begin
          if (frame_tick) begin
            if (death_cnt == DEATH_LAST) begin
              state     <= OVER;
              game_over <= 1'b1;
`ifdef HIGH_SCORE_EN
              if (score > high_score) high_score <= score;
`endif
            end else begin
              death_cnt <= death_cnt + 1'b1;
            end
          end
        end
        OVER: begin
          if (start) begin
            state     <= IDLE;
            game_over <= 1'b0;
            bird_rst  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // a fresh pipe re-arms scoring even if this cycle just scored
      if (pipe_new) pass_armed <= 1'b1;
    end
  end

`ifndef HIGH_SCORE_EN
  assign high_score = '0;
`endif

endmodule

// File: tb/tb_bird_collision_fsm.sv
// Directed self-checking bench for bird_collision_fsm; high_score expectations
// follow HIGH_SCORE_EN.
module tb_bird_collision_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic [9:0] bird_x0, bird_x1, bird_y0, bird_y1;
  logic [9:0] pipe_x, gap_top, gap_bot;
  logic       pipe_new;
  logic       game_active, game_over, collide, score_inc, bird_rst;
  logic [7:0] score, high_score;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bird_collision_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .bird_x0    (bird_x0),
    .bird_x1    (bird_x1),
    .bird_y0    (bird_y0),
    .bird_y1    (bird_y1),
    .pipe_x     (pipe_x),
    .gap_top    (gap_top),
    .gap_bot    (gap_bot),
    .pipe_new   (pipe_new),
    .game_active(game_active),
    .game_over  (game_over),
    .collide    (collide),
    .score_inc  (score_inc),
    .bird_rst   (bird_rst),
    .score      (score),
    .high_score (high_score)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // pulses are driven on a negedge; the following negedge sees the result
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic press();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic new_pipe();
    @(negedge clk) pipe_new = 1'b1;
    @(negedge clk) pipe_new = 1'b0;
  endtask

  task automatic safe_bird();
    bird_x0 = 10'd160; bird_x1 = 10'd160;
    bird_y1 = 10'd233; bird_y0 = 10'd247;
    gap_top = 10'd200; gap_bot = 10'd280;
  endtask

  task automatic score_n(input int n);
    pipe_x = 10'd100;
    for (int i = 0; i < n; i++) begin
      new_pipe();
      tick();
    end
  endtask

  // floor hit then DEATH_TICKS ticks; ends in OVER
  task automatic die();
    bird_y0 = 10'd479;
    tick();
    for (int i = 0; i < 4; i++) tick();
    bird_y0 = 10'd247;
  endtask

  function automatic int hs(input int v);
`ifdef HIGH_SCORE_EN
    return v;
`else
    return 0;
`endif
  endfunction

  int n_inc, inc_at, n_col;

  initial begin
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0; pipe_new = 1'b0;
    safe_bird();
    pipe_x = 10'd200;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_score", score, 0);
    chk("rst_active", game_active, 0);
    chk("rst_over", game_over, 0);
    chk("rst_bird_rst", bird_rst, 0);
    chk("rst_hs", high_score, 0);

    press();
    chk("start_active", game_active, 1);
    press();
    chk("start2_active", game_active, 1);
    chk("start2_score", score, 0);

    for (int pass = 1; pass <= 2; pass++) begin
      n_inc = 0; inc_at = -1; n_col = 0;
      for (int px = 200; px >= 100; px--) begin
        pipe_x = 10'(px);
        tick();
        if (score_inc) begin n_inc++; inc_at = px; end
        if (collide) n_col++;
      end
      chk("pass_collide", n_col, 0);
      chk("pass_inc_count", n_inc, 1);
      chk("pass_inc_at", inc_at, 119);
      chk("pass_score", score, pass);
      new_pipe();
    end

    bird_y0 = 10'd479;
    tick();
    chk("floor_collide", collide, 1);
    chk("floor_active", game_active, 0);
    @(negedge clk);
    chk("collide_pulse", collide, 0);
    bird_y0 = 10'd247;
    for (int i = 0; i < 3; i++) tick();
    chk("dying3_over", game_over, 0);
    tick();
    chk("dying4_over", game_over, 1);
    chk("hs_after2", high_score, hs(2));
    press();
    chk("bird_rst", bird_rst, 1);
    chk("idle_over", game_over, 0);
    chk("idle_score_hold", score, 2);
    @(negedge clk);
    chk("bird_rst_pulse", bird_rst, 0);
    press();
    chk("restart_active", game_active, 1);
    chk("restart_score", score, 0);

    bird_y1 = 10'd1020; bird_y0 = 10'd5;
    tick();
    chk("ceil_collide", collide, 1);
    safe_bird();
    for (int i = 0; i < 4; i++) tick();
    chk("ceil_over", game_over, 1);
    chk("hs_hold", high_score, hs(2));
    press(); press();

    pipe_x = 10'd150; bird_y1 = 10'd190;
    tick();
    chk("pipe_collide", collide, 1);
    chk("pipe_no_inc", score_inc, 0);
    chk("pipe_score", score, 0);
    safe_bird();
    for (int i = 0; i < 4; i++) tick();
    press(); press();

    score_n(3);
    chk("hs_run_score3", score, 3);
    die();
    chk("hs_over3", game_over, 1);
    chk("hs_3", high_score, hs(3));
    press(); press();
    score_n(1);
    chk("hs_run_score1", score, 1);
    die();
    chk("hs_keep3", high_score, hs(3));
    press(); press();

    pipe_x = 10'd100;
    new_pipe();
    @(negedge clk) begin frame_tick = 1'b1; pipe_new = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; pipe_new = 1'b0; end
    chk("same_cyc_inc", score_inc, 1);
    tick();
    chk("rearm_inc", score_inc, 1);
    chk("rearm_score", score, 2);

    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("midrst_score", score, 0);
    chk("midrst_active", game_active, 0);
    chk("midrst_hs", high_score, 0);
    press();
    chk("midrst_start", game_active, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bird_collision_fsm.md
Name: bird_collision_fsm

Overview:
Game-control stage directly downstream of the bird position block. Each frame tick it takes the bird bounding box and the current pipe pair, and detects collisions with the floor, the ceiling and the pipes. It runs the game state machine (IDLE/PLAYING/DYING/OVER) and keeps the score. Its outputs gate bird/pipe motion (game_active), request a bird restart (bird_rst) and feed the display/score logic.

Parameters:
N, 10, coordinate width (matches bird block)
PIPE_W, 40, pipe width in pixels
FLOOR_Y, 479, bird_y0 >= FLOOR_Y is a floor hit
SCORE_W, 8, score width; score saturates at all-ones
DEATH_TICKS, 4, frame ticks spent in DYING before OVER

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse; all evaluation is sampled on it
start  in  1  one-cycle start/flap pulse (already edge-detected)
bird_x0  in  N  bird left edge
bird_x1  in  N  bird right edge (may equal bird_x0)
bird_y0  in  N  bird bottom edge (larger y)
bird_y1  in  N  bird top edge (smaller y)
pipe_x  in  N  pipe left edge
gap_top  in  N  first open row of gap
gap_bot  in  N  last open row of gap
pipe_new  in  1  pulse: a fresh pipe has been loaded; re-arms scoring
game_active  out  1  high only in PLAYING
game_over  out  1  high only in OVER
collide  out  1  one-cycle pulse on detected hit
score_inc  out  1  one-cycle pulse when score increments
bird_rst  out  1  one-cycle pulse on OVER->IDLE
score  out  SCORE_W  current score
high_score  out  SCORE_W  best score (see Optional Feature)

Behaviour:
- Reset: state IDLE; every output 0; pass_armed=1; death counter 0.
- Hit terms are combinational from the inputs and are registered only when frame_tick=1 in PLAYING.
  - floor: bird_y0 >= FLOOR_Y.
  - ceiling: bird_y1 == 0, or bird_y1 > bird_y0. The second case catches underflow wrap of the bird's top edge.
  - pipe: horizontal overlap (bird_x1 >= pipe_x and bird_x0 <= pipe_x+PIPE_W-1) and vertical miss (bird_y1 < gap_top or bird_y0 > gap_bot).
  - Pipe right edge is computed at N+1 bits, so it never wraps.
- passed = (pipe_x+PIPE_W) < bird_x0, computed at N+1 bits.
- IDLE: start -> PLAYING next cycle. score is cleared to 0 on this transition.
- PLAYING, frame_tick with any hit: collide=1 for one cycle, then -> DYING with counter=0. The score is not incremented on that tick, even if passed.
- PLAYING, frame_tick with no hit, passed=1 and pass_armed=1: score+1 (saturating), score_inc=1, pass_armed cleared.
- pipe_new re-arms pass_armed in any state. If pipe_new and a score event fall on the same cycle, the score counts first and pass_armed ends at 1.
- start is ignored in PLAYING and DYING.
- DYING: counter increments on each frame_tick. On the DEATH_TICKS-th tick -> OVER.
- OVER: game_over=1. start -> IDLE with bird_rst=1 for one cycle; score holds until the next IDLE->PLAYING.
- Output latency: collide/score_inc assert in the cycle after the sampling frame_tick edge. game_active drops on that same cycle.
- Reset mid-operation returns to IDLE and clears the score; high_score also clears.

Optional Feature:
Macro HIGH_SCORE_EN.
- Defined: a high_score register updates on the DYING->OVER transition when score > high_score. It persists across restarts and is cleared only by reset.
- Not defined: high_score is tied to 0 and no register is built. The port list is unchanged.

Decomposition:
- Package flappy_pkg: state enum game_state_t {IDLE, PLAYING, DYING, OVER}, SCREEN_W=640, SCREEN_H=480, and the default PIPE_W/FLOOR_Y constants shared with the pipe and bird blocks.
- Sub-module box_hit: purely combinational, parameterised by N. Inputs are the bird box plus pipe/gap; outputs are floor/ceiling/pipe hit bits and passed.

Test Plan:
- Reset, then idle 10 cycles -> state IDLE; score=0, game_active=0, game_over=0, bird_rst=0.
- start in IDLE -> game_active=1 next cycle. A second start in PLAYING has no effect.
- Bird at x0=x1=160, y1=233, y0=247; gap 200..280; pipe_x stepped 200->100 by 1 per tick -> no collide. score_inc fires exactly once, at the tick where pipe_x=119; score=1. pipe_new, then repeat -> score=2.
- Bird at y0=479 on a tick -> collide pulse, game_active=0. After 4 ticks game_over=1. start -> bird_rst pulse; state IDLE.
- Ceiling wrap: bird_y1=1020, bird_y0=5 on a tick -> collide. Pipe hit: pipe_x=150, y1=190, gap_top=200 -> collide, and score does not increment on that tick.
- With HIGH_SCORE_EN: play to score 3, die, restart, play to score 1, die -> high_score=3. Without the macro, high_score stays 0 throughout.
